// File: rtl/ysyx_23060025_lsu_ctrl_if.sv
// Memory request/response bus between the LSU controller and the data memory.
// The request channel carries one access per handshake. The response channel
// returns one word, no earlier than the cycle after the request handshake.
interface ysyx_23060025_lsu_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid_o;
   logic                  req_ready_i;
   logic                  req_wen_o;
   logic [ADDR_WIDTH-1:0] req_addr_o;
   logic [DATA_WIDTH-1:0] req_wdata_o;
   logic [3:0]            req_wstrb_o;
   logic [1:0]            req_size_o;
   logic                  resp_valid_i;
   logic                  resp_ready_o;
   logic [DATA_WIDTH-1:0] resp_rdata_i;
   logic                  resp_err_i;

   // LSU side: issues requests and consumes responses.
   modport master (
      output req_valid_o,
      output req_wen_o,
      output req_addr_o,
      output req_wdata_o,
      output req_wstrb_o,
      output req_size_o,
      output resp_ready_o,
      input  req_ready_i,
      input  resp_valid_i,
      input  resp_rdata_i,
      input  resp_err_i
   );

   // Memory side: accepts requests and produces responses.
   modport slave (
      input  req_valid_o,
      input  req_wen_o,
      input  req_addr_o,
      input  req_wdata_o,
      input  req_wstrb_o,
      input  req_size_o,
      input  resp_ready_o,
      output req_ready_i,
      output resp_valid_i,
      output resp_rdata_i,
      output resp_err_i
   );
endinterface

// File: rtl/ysyx_23060025_lsu_ctrl.sv
// LSU stage controller behind the EX/LSU pipeline register.
// Produces the register's load enable, runs one bus transaction per load or
// store, aligns and extends load data, and hands results to WBU.
// Non-memory instructions pass straight to DONE in one cycle.
module ysyx_23060025_lsu_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   // EX side, seen before the EX/LSU register
   input  logic                  f_ex_valid_i,
   input  logic                  f_ex_mem_wen_i,
   input  logic [2:0]            f_ex_load_type_i,
   output logic                  t_lsu_ready_o,
   // EX/LSU register contents
   input  logic                  f_lsu_mem_wen_i,
   input  logic [2:0]            f_lsu_load_type_i,
   input  logic [1:0]            f_lsu_store_type_i,
   input  logic [ADDR_WIDTH-1:0] f_lsu_addr_i,
   input  logic [DATA_WIDTH-1:0] f_lsu_wdata_i,
   // Memory bus
   ysyx_23060025_lsu_ctrl_if.master mem,
   // WBU handoff
   output logic                  t_lsu_valid_o,
   input  logic                  f_wbu_ready_i,
   output logic [DATA_WIDTH-1:0] t_lsu_rdata_o,
   output logic                  t_lsu_err_o,
   output logic                  t_lsu_misalign_o
);

   localparam logic [2:0] LdNone = 3'd0;
   localparam logic [2:0] LdLb   = 3'd1;
   localparam logic [2:0] LdLh   = 3'd2;
   localparam logic [2:0] LdLw   = 3'd3;
   localparam logic [2:0] LdLbu  = 3'd4;
   localparam logic [2:0] LdLhu  = 3'd5;

   localparam logic [1:0] StSb = 2'd0;
   localparam logic [1:0] StSh = 2'd1;

   localparam logic [1:0] SzByte = 2'd0;
   localparam logic [1:0] SzHalf = 2'd1;
   localparam logic [1:0] SzWord = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StResp,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  mis_q, mis_d;

   logic [1:0]            off;
   logic [1:0]            size;
   logic                  misalign;
   logic [3:0]            wstrb;
   logic [DATA_WIDTH-1:0] rshift;
   logic [DATA_WIDTH-1:0] ld_ext;
   logic                  lsu_ready;
   logic                  accept;

   assign off = f_lsu_addr_i[1:0];

   // Access size from the registered instruction; unknown codes act as word.
   always_comb begin
      size = SzWord;
      if (f_lsu_mem_wen_i) begin
         case (f_lsu_store_type_i)
            StSb:    size = SzByte;
            StSh:    size = SzHalf;
            default: size = SzWord;
         endcase
      end else begin
         case (f_lsu_load_type_i)
            LdLb, LdLbu: size = SzByte;
            LdLh, LdLhu: size = SzHalf;
            default:     size = SzWord;
         endcase
      end
   end

   // Alignment check and store byte lanes, all from the held register contents.
   always_comb begin
      misalign = ((size == SzHalf) && off[0]) || ((size == SzWord) && (off != 2'b00));
      wstrb    = 4'b0000;
      if (f_lsu_mem_wen_i) begin
         case (size)
            SzByte:  wstrb = 4'b0001 << off;
            SzHalf:  wstrb = 4'b0011 << off;
            default: wstrb = 4'b1111;
         endcase
      end
   end

   // Load data: shift the addressed lane down, then sign/zero extend.
   always_comb begin
      rshift = mem.resp_rdata_i >> {off, 3'b000};
      case (f_lsu_load_type_i)
         LdLb:    ld_ext = {{(DATA_WIDTH - 8){rshift[7]}}, rshift[7:0]};
         LdLh:    ld_ext = {{(DATA_WIDTH - 16){rshift[15]}}, rshift[15:0]};
         LdLbu:   ld_ext = {{(DATA_WIDTH - 8){1'b0}}, rshift[7:0]};
         LdLhu:   ld_ext = {{(DATA_WIDTH - 16){1'b0}}, rshift[15:0]};
         LdLw:    ld_ext = rshift;
         default: ld_ext = rshift;
      endcase
   end

   // Request fields follow the register directly; they stay stable because
   // t_lsu_ready_o is low for the whole transaction.
   assign mem.req_wen_o   = f_lsu_mem_wen_i;
   assign mem.req_addr_o  = f_lsu_addr_i;
   assign mem.req_wdata_o = f_lsu_wdata_i << {off, 3'b000};
   assign mem.req_wstrb_o = wstrb;
   assign mem.req_size_o  = size;

   assign lsu_ready = (state_q == StIdle) || ((state_q == StDone) && f_wbu_ready_i);
   assign accept    = f_ex_valid_i && lsu_ready;

   // Next-state, result capture and handshake outputs.
   always_comb begin
      state_d          = state_q;
      rdata_d          = rdata_q;
      err_d            = err_q;
      mis_d            = mis_q;
      mem.req_valid_o  = 1'b0;
      mem.resp_ready_o = 1'b0;
      t_lsu_valid_o    = 1'b0;

      unique case (state_q)
         StIdle: begin
         end
         StReq: begin
            // Misaligned accesses never reach the bus.
            if (misalign) begin
               mis_d   = 1'b1;
               state_d = StDone;
            end else begin
               mem.req_valid_o = 1'b1;
               if (mem.req_ready_i) begin
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            mem.resp_ready_o = 1'b1;
            if (mem.resp_valid_i) begin
               err_d = mem.resp_err_i;
               if (mem.resp_err_i || f_lsu_mem_wen_i || (f_lsu_load_type_i == LdNone)) begin
                  rdata_d = '0;
               end else begin
                  rdata_d = ld_ext;
               end
               state_d = StDone;
            end
         end
         StDone: begin
            t_lsu_valid_o = 1'b1;
            if (f_wbu_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A new instruction overrides the above, allowing DONE -> REQ/DONE with no bubble.
      if (accept) begin
         rdata_d = '0;
         err_d   = 1'b0;
         mis_d   = 1'b0;
         state_d = (f_ex_mem_wen_i || (f_ex_load_type_i != LdNone)) ? StReq : StDone;
      end
   end

   // State and result registers, synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         rdata_q <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign t_lsu_ready_o    = lsu_ready;
   assign t_lsu_rdata_o    = rdata_q;
   assign t_lsu_err_o      = err_q;
   assign t_lsu_misalign_o = mis_q;

endmodule

// File: tb/tb_ysyx_23060025_lsu_ctrl.sv
// Bench for the LSU controller: EX/LSU register model, a simple memory
// responder, and scoreboards for bus requests and WBU results.
module tb_ysyx_23060025_lsu_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid, ex_wen;
   logic [2:0]  ex_ltype;
   logic [1:0]  ex_stype;
   logic [31:0] ex_addr, ex_wdata;
   logic        lsu_wen;
   logic [2:0]  lsu_ltype;
   logic [1:0]  lsu_stype;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        dut_ready, dut_valid, wbu_ready, dut_err, dut_mis;
   logic [31:0] dut_rdata;

   logic [31:0] mem_word;
   logic        mem_err;
   int          cfg_stall;

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  size;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      int          lat;
   } res_t;

   req_t req_q[$];
   res_t res_q[$];
   int   acc_q[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always #5 clock = ~clock;

   ysyx_23060025_lsu_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

   ysyx_23060025_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clock              (clock),
      .reset              (reset),
      .f_ex_valid_i       (ex_valid),
      .f_ex_mem_wen_i     (ex_wen),
      .f_ex_load_type_i   (ex_ltype),
      .t_lsu_ready_o      (dut_ready),
      .f_lsu_mem_wen_i    (lsu_wen),
      .f_lsu_load_type_i  (lsu_ltype),
      .f_lsu_store_type_i (lsu_stype),
      .f_lsu_addr_i       (lsu_addr),
      .f_lsu_wdata_i      (lsu_wdata),
      .mem                (mem_if),
      .t_lsu_valid_o      (dut_valid),
      .f_wbu_ready_i      (wbu_ready),
      .t_lsu_rdata_o      (dut_rdata),
      .t_lsu_err_o        (dut_err),
      .t_lsu_misalign_o   (dut_mis)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // EX/LSU pipeline register, loaded by t_lsu_ready_o.
   always @(posedge clock) begin
      if (reset) begin
         lsu_wen   <= 1'b0;
         lsu_ltype <= 3'd0;
         lsu_stype <= 2'd0;
         lsu_addr  <= 32'd0;
         lsu_wdata <= 32'd0;
      end else if (ex_valid && dut_ready) begin
         lsu_wen   <= ex_wen;
         lsu_ltype <= ex_ltype;
         lsu_stype <= ex_stype;
         lsu_addr  <= ex_addr;
         lsu_wdata <= ex_wdata;
      end
   end

   // Memory: request ready after cfg_stall cycles, response the cycle after handshake.
   initial begin
      automatic logic hs, rs, st, rst_s;
      automatic int   stall_cnt = 0;
      mem_if.req_ready_i  = 1'b0;
      mem_if.resp_valid_i = 1'b0;
      mem_if.resp_rdata_i = 32'd0;
      mem_if.resp_err_i   = 1'b0;
      forever begin
         @(negedge clock);
         rst_s = reset;
         hs    = mem_if.req_valid_o && mem_if.req_ready_i;
         st    = mem_if.req_valid_o && !mem_if.req_ready_i;
         rs    = mem_if.resp_valid_i && mem_if.resp_ready_o;
         @(posedge clock);
         #1;
         if (rst_s) begin
            mem_if.resp_valid_i = 1'b0;
            stall_cnt = cfg_stall;
         end else begin
            if (rs) mem_if.resp_valid_i = 1'b0;
            if (hs) begin
               mem_if.resp_valid_i = 1'b1;
               mem_if.resp_rdata_i = mem_word;
               mem_if.resp_err_i   = mem_err;
            end
            if (st) stall_cnt--;
            else if (!mem_if.req_valid_o) stall_cnt = cfg_stall;
         end
         mem_if.req_ready_i = (stall_cnt == 0);
      end
   end

   // Monitor: request fields (also while stalled), results, latency.
   initial begin
      automatic req_t r;
      automatic res_t e;
      automatic int   a;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            acc_q.delete();
         end else begin
            if (ex_valid && dut_ready) acc_q.push_back(cyc);
            if (mem_if.req_valid_o) begin
               if (req_q.size() == 0) begin
                  check("req_unexpected", 32'(mem_if.req_valid_o), 32'd0);
               end else begin
                  r = req_q[0];
                  check("req_wen", 32'(mem_if.req_wen_o), 32'(r.wen));
                  check("req_addr", mem_if.req_addr_o, r.addr);
                  if (r.wen) check("req_wdata", mem_if.req_wdata_o, r.wdata);
                  check("req_wstrb", 32'(mem_if.req_wstrb_o), 32'(r.wstrb));
                  check("req_size", 32'(mem_if.req_size_o), 32'(r.size));
                  if (mem_if.req_ready_i) void'(req_q.pop_front());
               end
            end
            if (dut_valid) begin
               if (res_q.size() == 0) begin
                  check("res_unexpected", 32'(dut_valid), 32'd0);
               end else begin
                  e = res_q[0];
                  check("rdata", dut_rdata, e.rdata);
                  check("err", 32'(dut_err), 32'(e.err));
                  check("misalign", 32'(dut_mis), 32'(e.mis));
                  check("lsu_ready_done", 32'(dut_ready), 32'(wbu_ready));
                  if (wbu_ready) begin
                     void'(res_q.pop_front());
                     a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                     if (e.lat != 0) check("latency", 32'(cyc - a), 32'(e.lat));
                  end
               end
            end
         end
      end
   end

   task automatic set_mem(input logic [31:0] word, input logic err, input int stall);
      mem_word  = word;
      mem_err   = err;
      cfg_stall = stall;
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic wen, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                        input logic [1:0] e_size, input logic [31:0] e_rdata,
                        input logic e_err, input logic e_mis, input int lat);
      req_t r;
      res_t e;
      logic ok;
      ex_valid = 1'b1;
      ex_wen   = wen;
      ex_ltype = lt;
      ex_stype = st;
      ex_addr  = addr;
      ex_wdata = wdata;
      if ((wen || (lt != 3'd0)) && !e_mis) begin
         r.wen = wen; r.addr = addr; r.wdata = e_wdata; r.wstrb = e_wstrb; r.size = e_size;
         req_q.push_back(r);
      end
      e.rdata = e_rdata; e.err = e_err; e.mis = e_mis; e.lat = lat;
      res_q.push_back(e);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clock);
         if (dut_ready) ok = 1'b1;
      end
      check("accept", 32'(ok), 32'd1);
      @(posedge clock);
      #1;
      ex_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && res_q.size() != 0; i++) @(negedge clock);
      check("drain", 32'(res_q.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 32'(dut_ready), 32'd1);
      check({tag, "_valid"}, 32'(dut_valid), 32'd0);
      check({tag, "_req_valid"}, 32'(mem_if.req_valid_o), 32'd0);
      check({tag, "_resp_ready"}, 32'(mem_if.resp_ready_o), 32'd0);
      check({tag, "_rdata"}, dut_rdata, 32'd0);
      check({tag, "_err"}, 32'(dut_err), 32'd0);
      check({tag, "_mis"}, 32'(dut_mis), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      automatic logic ok;
      reset = 1'b1; ex_valid = 1'b0; ex_wen = 1'b0; ex_ltype = 3'd0; ex_stype = 2'd0;
      ex_addr = 32'd0; ex_wdata = 32'd0; wbu_ready = 1'b1;
      mem_word = 32'd0; mem_err = 1'b0; cfg_stall = 0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check_reset_vals("rst");
      @(posedge clock);
      #1;

      // Back-to-back ALU stream
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 3'd0, 2'd0, 32'h1000_0000 + 32'(i), 32'h5555_0000, 4'h0, 32'd0, 2'd2,
               32'd0, 1'b0, 1'b0, 1);
      end
      drain();

      // Loads and stores
      set_mem(32'h80AB_CDEF, 1'b0, 0);
      issue(1'b0, 3'd1, 2'd0, 32'h8000_0003, 32'd0, 4'h0, 32'd0, 2'd0,
            32'hFFFF_FF80, 1'b0, 1'b0, 3);
      drain();
      set_mem(32'h80AB_CDEF, 1'b0, 0);
      issue(1'b0, 3'd4, 2'd0, 32'h8000_0003, 32'd0, 4'h0, 32'd0, 2'd0,
            32'h0000_0080, 1'b0, 1'b0, 3);
      drain();
      set_mem(32'h8765_4321, 1'b0, 0);
      issue(1'b0, 3'd2, 2'd0, 32'h8000_0002, 32'd0, 4'h0, 32'd0, 2'd1,
            32'hFFFF_8765, 1'b0, 1'b0, 3);
      drain();
      set_mem(32'h8765_4321, 1'b0, 0);
      issue(1'b0, 3'd5, 2'd0, 32'h8000_0002, 32'd0, 4'h0, 32'd0, 2'd1,
            32'h0000_8765, 1'b0, 1'b0, 3);
      drain();
      set_mem(32'hFFFF_FFFF, 1'b0, 0);
      issue(1'b1, 3'd0, 2'd1, 32'h8000_0002, 32'h0000_1234, 4'hC, 32'h1234_0000, 2'd1,
            32'd0, 1'b0, 1'b0, 3);
      drain();
      set_mem(32'hFFFF_FFFF, 1'b0, 0);
      issue(1'b1, 3'd0, 2'd0, 32'h8000_0001, 32'h0000_00AB, 4'h2, 32'h0000_AB00, 2'd0,
            32'd0, 1'b0, 1'b0, 3);
      drain();
      set_mem(32'hFFFF_FFFF, 1'b0, 0);
      issue(1'b1, 3'd0, 2'd2, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 2'd2,
            32'd0, 1'b0, 1'b0, 3);
      drain();

      // Misaligned: no bus request, flag set
      issue(1'b0, 3'd3, 2'd0, 32'h8000_0001, 32'd0, 4'h0, 32'd0, 2'd2,
            32'd0, 1'b0, 1'b1, 2);
      drain();
      issue(1'b1, 3'd0, 2'd1, 32'h8000_0003, 32'h0000_BEEF, 4'h0, 32'd0, 2'd1,
            32'd0, 1'b0, 1'b1, 2);
      drain();

      // Request stalled 5 cycles
      set_mem(32'hDEAD_BEEF, 1'b0, 5);
      issue(1'b0, 3'd3, 2'd0, 32'h8000_0004, 32'd0, 4'h0, 32'd0, 2'd2,
            32'hDEAD_BEEF, 1'b0, 1'b0, 0);
      drain();

      // Bus error on LH with WBU stalled 3 cycles
      set_mem(32'h8000_1234, 1'b1, 0);
      wbu_ready = 1'b0;
      issue(1'b0, 3'd2, 2'd0, 32'h8000_0002, 32'd0, 4'h0, 32'd0, 2'd1,
            32'd0, 1'b1, 1'b0, 0);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         if (dut_valid) ok = 1'b1;
      end
      check("err_valid_seen", 32'(ok), 32'd1);
      repeat (3) @(posedge clock);
      #1;
      wbu_ready = 1'b1;
      drain();

      // Reset while in RESP
      set_mem(32'h2468_ACE0, 1'b0, 0);
      issue(1'b0, 3'd3, 2'd0, 32'h8000_0004, 32'd0, 4'h0, 32'd0, 2'd2,
            32'h2468_ACE0, 1'b0, 1'b0, 0);
      @(posedge clock);
      #1;
      check("in_resp", 32'(mem_if.resp_ready_o), 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      req_q.delete();
      res_q.delete();
      reset = 1'b0;
      @(negedge clock);
      check_reset_vals("midrst");
      @(posedge clock);
      #1;
      set_mem(32'h1357_9BDF, 1'b0, 0);
      issue(1'b0, 3'd3, 2'd0, 32'h8000_0008, 32'd0, 4'h0, 32'd0, 2'd2,
            32'h1357_9BDF, 1'b0, 1'b0, 3);
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
